// File: rtl/imm_gen_stage_pkg.sv
// -----------------------------------------------------------------------------
// imm_pkg
// Shared definitions for the immediate-generation stage:
//   - imm_src_t     : immediate format select carried on ImmSrc
//   - OPC_*         : RV base-ISA major opcodes that feed each immediate format
//   - XLEN_DEFAULT  : default datapath width (legal widths are 32 and 64)
// Optional build macro used by the decoder: IMM_ZICSR_EN (enables ZIMM).
// -----------------------------------------------------------------------------
package imm_pkg;

   localparam int XLEN_DEFAULT = 32;

   // Immediate format select, encoded exactly as presented on ImmSrc
   typedef enum logic [2:0] {
      IMM_I     = 3'b000,
      IMM_S     = 3'b001,
      IMM_B     = 3'b010,
      IMM_U     = 3'b011,
      IMM_J     = 3'b100,
      IMM_SHAMT = 3'b101,
      IMM_ZIMM  = 3'b110,
      IMM_RSVD  = 3'b111
   } imm_src_t;

   // Base-ISA major opcodes, kept here so the control decoder and this stage
   // agree on which instruction classes select which immediate format
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_stage_if.sv
// -----------------------------------------------------------------------------
// imm_gen_stage_if
// Upstream/downstream handshake bundle of the immediate-generation stage.
//   Upstream  : InValid, InReady, Instr[31:0], ImmSrc[2:0], InTag, Flush
//   Downstream: OutValid, OutReady, ImmExt[XLEN-1:0], OutTag, ImmIllegal
// master : the side that presents instructions and consumes immediates
// slave  : the stage itself
// -----------------------------------------------------------------------------
interface imm_gen_stage_if
   import imm_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 32
);

   logic              InValid;
   logic              InReady;
   logic [31:0]       Instr;
   logic [2:0]        ImmSrc;
   logic [TAG_W-1:0]  InTag;
   logic              Flush;
   logic              OutValid;
   logic              OutReady;
   logic [XLEN-1:0]   ImmExt;
   logic [TAG_W-1:0]  OutTag;
   logic              ImmIllegal;

   modport master (
      output InValid, Instr, ImmSrc, InTag, Flush, OutReady,
      input  InReady, OutValid, ImmExt, OutTag, ImmIllegal
   );

   modport slave (
      input  InValid, Instr, ImmSrc, InTag, Flush, OutReady,
      output InReady, OutValid, ImmExt, OutTag, ImmIllegal
   );

endinterface

// File: rtl/imm_gen_stage_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Pure combinational immediate extraction from a raw RV instruction word.
//   instr_i      : raw instruction word
//   immSrc_i     : format select (I, S, B, U, J, SHAMT, ZIMM, reserved)
//   immExt_o     : extended immediate, XLEN bits
//   immIllegal_o : the selected format is not supported in this build
// Build macro: IMM_ZICSR_EN enables the ZIMM (CSR immediate) format; without
// it ZIMM is handled like the reserved encoding.
// -----------------------------------------------------------------------------
module imm_decode
   import imm_pkg::*;
#(
   parameter int XLEN = XLEN_DEFAULT
)
(
   input  logic [31:0]     instr_i,
   input  imm_src_t        immSrc_i,
   output logic [XLEN-1:0] immExt_o,
   output logic            immIllegal_o
);

   // Signed intermediates so a size cast to XLEN sign-extends from bit 31
   logic signed [11:0] immI;
   logic signed [11:0] immS;
   logic signed [12:0] immB;
   logic signed [31:0] immU;
   logic signed [20:0] immJ;

   assign immI = instr_i[31:20];
   assign immS = {instr_i[31:25], instr_i[11:7]};
   assign immB = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
   assign immU = {instr_i[31:12], 12'b0};
   assign immJ = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

   // The opcode field never contributes to an immediate; the format is chosen
   // upstream and arrives on immSrc_i
   logic unusedOpcode;
   assign unusedOpcode = ^instr_i[6:0];

   // Format mux; anything unsupported reads as zero with the illegal flag set
   always_comb begin
      immExt_o     = '0;
      immIllegal_o = 1'b0;
      case (immSrc_i)
         IMM_I:     immExt_o = XLEN'(immI);
         IMM_S:     immExt_o = XLEN'(immS);
         IMM_B:     immExt_o = XLEN'(immB);
         IMM_U:     immExt_o = XLEN'(immU);
         IMM_J:     immExt_o = XLEN'(immJ);
         IMM_SHAMT: immExt_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
`ifdef IMM_ZICSR_EN
         IMM_ZIMM:  immExt_o = XLEN'(instr_i[19:15]);
`else
         IMM_ZIMM: begin
            immExt_o     = '0;
            immIllegal_o = 1'b1;
         end
`endif
         default: begin
            immExt_o     = '0;
            immIllegal_o = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/imm_gen_stage.sv
// -----------------------------------------------------------------------------
// imm_gen_stage
// Decodes the immediate of each incoming instruction and passes it downstream
// through a two-entry skid buffer (main register drives the outputs, skid
// register absorbs the one entry accepted while downstream stalls).
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : imm_gen_stage_if.slave (InValid/InReady/Instr/ImmSrc/InTag/Flush
//           in, OutValid/OutReady/ImmExt/OutTag/ImmIllegal out)
// Build macro: IMM_ZICSR_EN (forwarded to imm_decode, enables ZIMM).
// -----------------------------------------------------------------------------
module imm_gen_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int TAG_W = 32
)
(
   input logic           clk,
   input logic           rst_n,
   imm_gen_stage_if.slave bus
);

   localparam int ENTRY_W = XLEN + 1 + TAG_W;

   logic [XLEN-1:0]    decImm;
   logic               decIllegal;
   logic [ENTRY_W-1:0] inEntry;

   // Decode ahead of buffering so each stored entry is already final
   imm_decode #(.XLEN(XLEN)) uDecode (
      .instr_i      (bus.Instr),
      .immSrc_i     (imm_src_t'(bus.ImmSrc)),
      .immExt_o     (decImm),
      .immIllegal_o (decIllegal)
   );

   assign inEntry = {decImm, decIllegal, bus.InTag};

   logic               mainValid_q, mainValid_d;
   logic               skidValid_q, skidValid_d;
   logic [ENTRY_W-1:0] mainData_q, mainData_d;
   logic [ENTRY_W-1:0] skidData_q, skidData_d;
   logic               inReady_q;
   logic               accept;
   logic               drain;

   assign accept = bus.InValid & inReady_q;
   assign drain  = mainValid_q & bus.OutReady;

   // Next-state of the two entries. Flush wins over everything. When main is
   // free (empty or draining) it refills from skid first to keep ordering,
   // otherwise from the input; a stalled main sends the new entry to skid.
   // Data registers only change when loaded, so stalled outputs hold steady.
   always_comb begin
      mainValid_d = mainValid_q;
      skidValid_d = skidValid_q;
      mainData_d  = mainData_q;
      skidData_d  = skidData_q;
      if (bus.Flush) begin
         mainValid_d = 1'b0;
         skidValid_d = 1'b0;
      end else if (!mainValid_q || drain) begin
         if (skidValid_q) begin
            mainValid_d = 1'b1;
            mainData_d  = skidData_q;
            skidValid_d = accept;
            if (accept) begin
               skidData_d = inEntry;
            end
         end else begin
            mainValid_d = accept;
            if (accept) begin
               mainData_d = inEntry;
            end
         end
      end else if (accept) begin
         skidValid_d = 1'b1;
         skidData_d  = inEntry;
      end
   end

   // State registers; InReady is the registered inverse of the next skid
   // state, so it sits at 0 in reset and rises on the first edge after it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mainValid_q <= 1'b0;
         skidValid_q <= 1'b0;
         mainData_q  <= '0;
         skidData_q  <= '0;
         inReady_q   <= 1'b0;
      end else begin
         mainValid_q <= mainValid_d;
         skidValid_q <= skidValid_d;
         mainData_q  <= mainData_d;
         skidData_q  <= skidData_d;
         inReady_q   <= !skidValid_d;
      end
   end

   assign bus.InReady  = inReady_q;
   assign bus.OutValid = mainValid_q;
   assign {bus.ImmExt, bus.ImmIllegal, bus.OutTag} = mainData_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// -----------------------------------------------------------------------------
// tb_imm_gen_stage
// Drives an XLEN=32 and an XLEN=64 instance of imm_gen_stage with identical
// stimulus and checks both against a behavioural model (immediate values
// computed arithmetically, buffer occupancy kept as a queue).
// -----------------------------------------------------------------------------
module tb_imm_gen_stage;

   logic        clk;
   logic        rst_n;
   logic        inValid;
   logic [31:0] instr;
   logic [2:0]  immSrc;
   logic [31:0] inTag;
   logic        flush;
   logic        outReady;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      logic [2:0]  src;
      logic [31:0] tag;
   } txn_t;

   imm_gen_stage_if #(.XLEN(32), .TAG_W(32)) if32 ();
   imm_gen_stage_if #(.XLEN(64), .TAG_W(32)) if64 ();

   assign if32.InValid  = inValid;
   assign if32.Instr    = instr;
   assign if32.ImmSrc   = immSrc;
   assign if32.InTag    = inTag;
   assign if32.Flush    = flush;
   assign if32.OutReady = outReady;
   assign if64.InValid  = inValid;
   assign if64.Instr    = instr;
   assign if64.ImmSrc   = immSrc;
   assign if64.InTag    = inTag;
   assign if64.Flush    = flush;
   assign if64.OutReady = outReady;

   imm_gen_stage #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32));
   imm_gen_stage #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst_n(rst_n), .bus(if64));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Immediate value by weighting instruction bits; the sign bit carries
   // negative weight. Returns {illegal, 64-bit value truncated to xlen}.
   function automatic logic [64:0] refImm(input logic [31:0] ins, input logic [2:0] src, input int xlen);
      longint      v;
      logic        ill;
      logic [63:0] uv;
      v   = 0;
      ill = 1'b0;
      case (src)
         3'd0: begin
            v = longint'(ins[31:20]);
            if (ins[31]) v = v - 4096;
         end
         3'd1: begin
            v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
            if (ins[31]) v = v - 4096;
         end
         3'd2: begin
            v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            if (ins[31]) v = v - 4096;
         end
         3'd3: begin
            v = longint'(ins[31:12]) * 4096;
            if (ins[31]) v = v - 64'sh1_0000_0000;
         end
         3'd4: begin
            v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            if (ins[31]) v = v - 1048576;
         end
         3'd5: v = (xlen == 32) ? longint'(ins[24:20]) : longint'(ins[25:20]);
         3'd6: begin
`ifdef IMM_ZICSR_EN
            v = longint'(ins[19:15]);
`else
            ill = 1'b1;
`endif
         end
         default: ill = 1'b1;
      endcase
      uv = v;
      if (xlen == 32) uv = {32'h0, uv[31:0]};
      return {ill, uv};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; inValid = 1'b0; instr = '0; immSrc = '0; inTag = '0; flush = 1'b0; outReady = 1'b0;
      repeat (2) @(negedge clk);
      total++; if (if32.OutValid !== 1'b0 || if64.OutValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_outvalid got %b/%b want 0", if32.OutValid, if64.OutValid); end
      total++; if (if32.InReady !== 1'b0 || if64.InReady !== 1'b0) begin bad++; $display("[TB] FAIL reset_inready got %b/%b want 0", if32.InReady, if64.InReady); end
      total++; if (if32.ImmExt !== 32'h0 || if64.ImmExt !== 64'h0) begin bad++; $display("[TB] FAIL reset_immext got %h/%h want 0", if32.ImmExt, if64.ImmExt); end
      total++; if (if32.OutTag !== 32'h0 || if32.ImmIllegal !== 1'b0) begin bad++; $display("[TB] FAIL reset_tag_ill got %h/%b want 0/0", if32.OutTag, if32.ImmIllegal); end
      rst_n = 1'b1;
      #1;
      total++; if (if32.InReady !== 1'b0) begin bad++; $display("[TB] FAIL release_inready_early got %b want 0", if32.InReady); end
      @(posedge clk); #1;
      total++; if (if32.InReady !== 1'b1 || if64.InReady !== 1'b1) begin bad++; $display("[TB] FAIL release_inready got %b/%b want 1", if32.InReady, if64.InReady); end
   endtask

   task automatic test_formats();
      logic [31:0] vInstr [6];
      logic [2:0]  vSrc   [6];
      logic [31:0] vExp32 [6];
      logic [63:0] vExp64 [6];
      logic        vIll   [6];
      vInstr[0] = 32'hFFF00093; vSrc[0] = 3'd0; vExp32[0] = 32'hFFFFFFFF; vExp64[0] = 64'hFFFFFFFFFFFFFFFF; vIll[0] = 1'b0;
      vInstr[1] = 32'hFE000EE3; vSrc[1] = 3'd2; vExp32[1] = 32'hFFFFFFFC; vExp64[1] = 64'hFFFFFFFFFFFFFFFC; vIll[1] = 1'b0;
      vInstr[2] = 32'h800000B7; vSrc[2] = 3'd3; vExp32[2] = 32'h80000000; vExp64[2] = 64'hFFFFFFFF80000000; vIll[2] = 1'b0;
      vInstr[3] = 32'h03F00000; vSrc[3] = 3'd5; vExp32[3] = 32'h0000001F; vExp64[3] = 64'h000000000000003F; vIll[3] = 1'b0;
      vInstr[4] = 32'hFFFFFFFF; vSrc[4] = 3'd7; vExp32[4] = 32'h00000000; vExp64[4] = 64'h0000000000000000; vIll[4] = 1'b1;
`ifdef IMM_ZICSR_EN
      vInstr[5] = 32'h000A8000; vSrc[5] = 3'd6; vExp32[5] = 32'h00000015; vExp64[5] = 64'h0000000000000015; vIll[5] = 1'b0;
`else
      vInstr[5] = 32'h000A8000; vSrc[5] = 3'd6; vExp32[5] = 32'h00000000; vExp64[5] = 64'h0000000000000000; vIll[5] = 1'b1;
`endif
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         inValid = 1'b1; instr = vInstr[i]; immSrc = vSrc[i]; inTag = 32'h100 + i; outReady = 1'b1;
         @(negedge clk);
         inValid = 1'b0;
         total++; if (if32.OutValid !== 1'b1 || if64.OutValid !== 1'b1) begin bad++; $display("[TB] FAIL fmt%0d_latency got %b/%b want 1", i, if32.OutValid, if64.OutValid); end
         total++; if (if32.ImmExt !== vExp32[i]) begin bad++; $display("[TB] FAIL fmt%0d_imm32 got %h want %h", i, if32.ImmExt, vExp32[i]); end
         total++; if (if64.ImmExt !== vExp64[i]) begin bad++; $display("[TB] FAIL fmt%0d_imm64 got %h want %h", i, if64.ImmExt, vExp64[i]); end
         total++; if (if32.ImmIllegal !== vIll[i] || if64.ImmIllegal !== vIll[i]) begin bad++; $display("[TB] FAIL fmt%0d_illegal got %b/%b want %b", i, if32.ImmIllegal, if64.ImmIllegal, vIll[i]); end
         total++; if (if32.OutTag !== 32'h100 + i) begin bad++; $display("[TB] FAIL fmt%0d_tag got %h want %h", i, if32.OutTag, 32'h100 + i); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      logic [31:0] got32 [$];
      logic [31:0] got64 [$];
      bit          acc3;
      acc3 = 1'b0;
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b1; instr = $urandom; immSrc = 3'd0; inTag = 32'd1;
      @(negedge clk);
      inTag = 32'd2;
      @(negedge clk);
      inTag = 32'd3;
      for (int k = 0; k < 2; k++) begin
         total++; if (if32.InReady !== 1'b0 || if64.InReady !== 1'b0) begin bad++; $display("[TB] FAIL b2b_full_inready%0d got %b/%b want 0", k, if32.InReady, if64.InReady); end
         total++; if (if32.OutTag !== 32'd1 || if32.OutValid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_hold%0d got tag %0d valid %b want 1/1", k, if32.OutTag, if32.OutValid); end
         @(negedge clk);
      end
      outReady = 1'b1;
      for (int k = 0; k < 12; k++) begin
         if (acc3) inValid = 1'b0;
         if (if32.OutValid) got32.push_back(if32.OutTag);
         if (if64.OutValid) got64.push_back(if64.OutTag);
         if (inValid && if32.InReady) acc3 = 1'b1;
         @(negedge clk);
      end
      inValid = 1'b0;
      total++; if (got32.size() != 3 || got64.size() != 3) begin bad++; $display("[TB] FAIL b2b_count got %0d/%0d want 3", got32.size(), got64.size()); end
      for (int k = 0; k < 3; k++) begin
         if (k < got32.size() && k < got64.size()) begin
            total++; if (got32[k] !== k + 1 || got64[k] !== k + 1) begin bad++; $display("[TB] FAIL b2b_order%0d got %0d/%0d want %0d", k, got32[k], got64[k], k + 1); end
         end
      end
   endtask

   task automatic test_flush();
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b1; instr = $urandom; immSrc = 3'd1; inTag = 32'hA1;
      @(negedge clk);
      inTag = 32'hA2;
      @(negedge clk);
      total++; if (if32.InReady !== 1'b0 || if32.OutValid !== 1'b1) begin bad++; $display("[TB] FAIL flush_prefill got rdy %b valid %b want 0/1", if32.InReady, if32.OutValid); end
      inTag = 32'hA3; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; inValid = 1'b0;
      total++; if (if32.OutValid !== 1'b0 || if64.OutValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_outvalid got %b/%b want 0", if32.OutValid, if64.OutValid); end
      total++; if (if32.InReady !== 1'b1 || if64.InReady !== 1'b1) begin bad++; $display("[TB] FAIL flush_inready got %b/%b want 1", if32.InReady, if64.InReady); end
      outReady = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         total++; if (if32.OutValid !== 1'b0) begin bad++; $display("[TB] FAIL flush_leak%0d got tag %h valid %b want invalid", k, if32.OutTag, if32.OutValid); end
      end
      // one entry buffered and one arriving together with the flush
      outReady = 1'b0; inValid = 1'b1; inTag = 32'hB1;
      @(negedge clk);
      inTag = 32'hB2; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; inValid = 1'b0;
      total++; if (if32.OutValid !== 1'b0 || if32.InReady !== 1'b1) begin bad++; $display("[TB] FAIL flush_single got valid %b rdy %b want 0/1", if32.OutValid, if32.InReady); end
      outReady = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_random();
      txn_t        q [$];
      txn_t        t;
      logic [64:0] e32;
      logic [64:0] e64;
      bit          modelInRdy;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         total++; if (if32.OutValid !== (q.size() != 0) || if64.OutValid !== (q.size() != 0)) begin bad++; $display("[TB] FAIL rnd_outvalid c%0d got %b/%b want %b", c, if32.OutValid, if64.OutValid, q.size() != 0); end
         total++; if (if32.InReady !== (q.size() < 2) || if64.InReady !== (q.size() < 2)) begin bad++; $display("[TB] FAIL rnd_inready c%0d got %b/%b want %b", c, if32.InReady, if64.InReady, q.size() < 2); end
         if (q.size() != 0) begin
            e32 = refImm(q[0].instr, q[0].src, 32);
            e64 = refImm(q[0].instr, q[0].src, 64);
            total++; if (if32.ImmExt !== e32[31:0] || if32.ImmIllegal !== e32[64]) begin bad++; $display("[TB] FAIL rnd_imm32 c%0d got %h/%b want %h/%b", c, if32.ImmExt, if32.ImmIllegal, e32[31:0], e32[64]); end
            total++; if (if64.ImmExt !== e64[63:0] || if64.ImmIllegal !== e64[64]) begin bad++; $display("[TB] FAIL rnd_imm64 c%0d got %h/%b want %h/%b", c, if64.ImmExt, if64.ImmIllegal, e64[63:0], e64[64]); end
            total++; if (if32.OutTag !== q[0].tag || if64.OutTag !== q[0].tag) begin bad++; $display("[TB] FAIL rnd_tag c%0d got %h/%h want %h", c, if32.OutTag, if64.OutTag, q[0].tag); end
         end
         inValid  = ($urandom_range(0, 3) != 0);
         instr    = $urandom;
         immSrc   = 3'($urandom_range(0, 7));
         inTag    = $urandom;
         outReady = ($urandom_range(0, 2) != 0);
         flush    = ($urandom_range(0, 19) == 0);
         if (flush) begin
            q.delete();
         end else begin
            modelInRdy = (q.size() < 2);
            if (q.size() != 0 && outReady) void'(q.pop_front());
            if (inValid && modelInRdy) begin
               t.instr = instr; t.src = immSrc; t.tag = inTag;
               q.push_back(t);
            end
         end
      end
      @(negedge clk);
      inValid = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      outReady = 1'b0; inValid = 1'b1; instr = 32'hFFF00093; immSrc = 3'd0; inTag = 32'hC1;
      @(negedge clk);
      inTag = 32'hC2;
      @(negedge clk);
      inValid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total++; if (if32.OutValid !== 1'b0 || if64.OutValid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_outvalid got %b/%b want 0", if32.OutValid, if64.OutValid); end
      total++; if (if32.InReady !== 1'b0 || if32.ImmExt !== 32'h0 || if32.OutTag !== 32'h0) begin bad++; $display("[TB] FAIL midreset_outputs got rdy %b imm %h tag %h want 0", if32.InReady, if32.ImmExt, if32.OutTag); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (if32.InReady !== 1'b1 || if32.OutValid !== 1'b0) begin bad++; $display("[TB] FAIL midreset_release got rdy %b valid %b want 1/0", if32.InReady, if32.OutValid); end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_back_to_back();
      test_flush();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 32, width of the sideband tag carried with each immediate (PC or instruction ID).
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 InValid  input  1  an upstream instruction is presented.
REQ-006 InReady  output  1  the stage can accept this cycle.
REQ-007 Instr  input  32  raw instruction word.
REQ-008 ImmSrc  input  3  immediate format select.
REQ-009 InTag  input  TAG_W  sideband tag, paired with Instr.
REQ-010 Flush  input  1  discard all buffered and incoming entries.
REQ-011 OutValid  output  1  ImmExt, OutTag and ImmIllegal are valid.
REQ-012 OutReady  input  1  downstream accepts this cycle.
REQ-013 ImmExt  output  XLEN  sign- or zero-extended immediate.
REQ-014 OutTag  output  TAG_W  tag paired with ImmExt.
REQ-015 ImmIllegal  output  1  the ImmSrc encoding is unsupported.

Function
REQ-016 Each ImmSrc value SHALL select one format: 000 I, 001 S, 010 B, 011 U, 100 J, 101 SHAMT, 110 ZIMM, 111 reserved.
REQ-017 I/S/B/J SHALL follow the RV base formats, with bit 31 sign-extended to XLEN and bit 0 of B/J forced to 0.
REQ-018 U SHALL be {Instr[31:12],12'b0}, sign-extended to XLEN when XLEN=64.
REQ-019 SHAMT SHALL be a zero-extended field: Instr[24:20] when XLEN=32, Instr[25:20] when XLEN=64.
REQ-020 ImmSrc 111 SHALL yield ImmExt=0 and ImmIllegal=1; every other supported format SHALL yield ImmIllegal=0.
REQ-021 Decoding SHALL occur before buffering, so each stored entry holds {ImmExt, ImmIllegal, OutTag}.
REQ-022 The stage SHALL be a two-entry skid buffer made of a main register (drives the outputs) and a skid register.
REQ-023 A transfer SHALL occur on any edge where InValid and InReady are both 1, and on any edge where OutValid and OutReady are both 1.
REQ-024 Latency SHALL be one cycle (an entry accepted into an empty stage appears on the next cycle), and throughput SHALL be one entry per cycle.
REQ-025 On accept: if main is empty or draining, the entry SHALL load main; otherwise it SHALL load skid.
REQ-026 When main drains while skid is valid, skid SHALL move to main and skid SHALL become empty.
REQ-027 InReady SHALL be the registered inverse of skid-valid, so it is 0 while the skid register is full.
REQ-028 While OutValid=1 and OutReady=0, ImmExt, OutTag and ImmIllegal SHALL hold stable.
REQ-029 Ordering SHALL be preserved, with no loss and no duplication.
REQ-030 Flush SHALL have priority over all other events: on the next edge both entries are invalidated and any same-cycle input is dropped.
REQ-031 On the cycle after a flush, InReady SHALL be 1.

Reset
REQ-032 While rst_n=0, outputs SHALL read OutValid=0, InReady=0, ImmExt=0, OutTag=0, ImmIllegal=0, and both entries SHALL be invalid.
REQ-033 InReady SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 Reset asserted mid-transfer SHALL discard all entries immediately.

Configuration
REQ-035 With macro IMM_ZICSR_EN defined, ZIMM SHALL be the zero-extended Instr[19:15] with ImmIllegal=0.
REQ-036 Without IMM_ZICSR_EN, ZIMM SHALL be treated as reserved: ImmExt=0, ImmIllegal=1.

Structure
REQ-037 Package imm_pkg SHALL hold the imm_src_t enum, the base-ISA opcode constants and the XLEN default.
REQ-038 The pure combinational field extraction SHALL be the sub-module imm_decode, instantiated once at the input; the skid buffer logic SHALL reside in imm_gen_stage.

Verification
REQ-039 XLEN=32, Instr=32'hFFF00093, ImmSrc=000 -> one cycle later OutValid=1, ImmExt=32'hFFFFFFFF.
REQ-040 Instr=32'hFE000EE3, ImmSrc=010 -> ImmExt=32'hFFFFFFFC.
REQ-041 XLEN=64, Instr=32'h800000B7, ImmSrc=011 -> ImmExt=64'hFFFFFFFF80000000.
REQ-042 OutReady=0, present tags 1, 2, 3 back-to-back -> InReady=0 after tag 2 and tag 3 held; then OutReady=1 -> tags 1, 2, 3 output in order, once each.
REQ-043 Both entries full, InValid=1 and Flush=1 in the same cycle -> next cycle OutValid=0, InReady=1, and the flushed tag never appears.
REQ-044 ImmSrc=110, Instr[19:15]=5'b10101 -> IMM_ZICSR_EN defined: ImmExt=32'h15, ImmIllegal=0; not defined: ImmExt=0, ImmIllegal=1.
